clutmap_rw_ctrl: RTL and testbench

Clutter-map memory controller that sits directly upstream and downstream of the first-order recursion stage (recur_oper). For each incoming range/doppler cell it does the following:
- reads the stored clutter estimate y(n-1) from an internal map RAM;
- presents x(n) and y(n-1) to the recursion stage;
- writes the returned y(n) back to the same address.
It also forwards x(n) and y(n-1) to the detection stage. It handles map initialisation (first frame after reset or clear) and checks that write-backs line up with reads.

---
 rtl/clutmap_pkg.sv | 12 +
 rtl/clutmap_rw_ctrl_if.sv | 31 +++
 rtl/clutmap_ram.sv | 29 ++
 rtl/clutmap_rw_ctrl.sv | 136 +++++++++++++
 tb/tb_clutmap_rw_ctrl.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/clutmap_pkg.sv
// Shared constants for the clutter-map read/write controller: pipeline latencies
// and default map geometry.
package clutmap_pkg;

    localparam int RECUR_LAT  = 6;
    localparam int RD_LAT     = 1;
    localparam int WB_LAT     = RD_LAT + RECUR_LAT;

    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DAT_W  = 16;

endpackage

// File: rtl/clutmap_rw_ctrl_if.sv
// Cell input, recursion-stage operand/result and detector-side buses of the
// clutter-map controller. The slave side is the controller itself.
interface clutmap_rw_ctrl_if #(
    parameter int ADDR_W = 12,
    parameter int DAT_W  = 16
);
    logic              cell_vld;
    logic [DAT_W-1:0]  cell_din;
    logic [ADDR_W-1:0] cell_addr;

    logic              radmap_rd_vld;
    logic [DAT_W-1:0]  radmap_rd_din0;
    logic [DAT_W-1:0]  radmap_rd_din2;

    logic              recur_valid;
    logic [DAT_W-1:0]  recur_dat;

    logic              cm_vld;
    logic [DAT_W-1:0]  cm_x;
    logic [DAT_W-1:0]  cm_bg;

    modport master (
        output cell_vld, cell_din, cell_addr, recur_valid, recur_dat,
        input  radmap_rd_vld, radmap_rd_din0, radmap_rd_din2, cm_vld, cm_x, cm_bg
    );

    modport slave (
        input  cell_vld, cell_din, cell_addr, recur_valid, recur_dat,
        output radmap_rd_vld, radmap_rd_din0, radmap_rd_din2, cm_vld, cm_x, cm_bg
    );
endinterface

// File: rtl/clutmap_ram.sv
// Simple dual-port clutter map: one write port, one registered read port,
// read-first on address collision so a same-cycle read returns the old word.
module clutmap_ram
    import clutmap_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DAT_W  = DEF_DAT_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DAT_W-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DAT_W-1:0]  rdata
);

    logic [DAT_W-1:0] mem_q [2**ADDR_W];
    logic [DAT_W-1:0] rdata_q;

    // No reset: map contents and the read register must map onto block RAM.
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
        if (re) rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/clutmap_rw_ctrl.sv
// Clutter-map controller: reads y(n-1) per cell, feeds the recursion stage and
// detector, writes y(n) back via a pending-address FIFO, and manages init frames.
module clutmap_rw_ctrl
    import clutmap_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DAT_W       = DEF_DAT_W,
    parameter int AFIFO_DEPTH = 8
) (
    input  logic                 sys_clk,
    input  logic                 rst_n,
    input  logic                 frame_start,
    input  logic                 clear_map,
    clutmap_rw_ctrl_if.slave     bus,
    output logic                 init_frame,
    output logic [15:0]          frame_cnt,
    output logic                 wb_err
);

    localparam int PTR_W = (AFIFO_DEPTH > 1) ? $clog2(AFIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(AFIFO_DEPTH + 1);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(AFIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    logic [ADDR_W-1:0] afifo_q [AFIFO_DEPTH];
    logic [PTR_W-1:0]  afifo_wr_ptr_q, afifo_wr_ptr_d;
    logic [PTR_W-1:0]  afifo_rd_ptr_q, afifo_rd_ptr_d;
    logic [CNT_W-1:0]  afifo_cnt_q, afifo_cnt_d;
    logic              afifo_full, afifo_empty, push_ok, pop_ok;

    logic              rd_vld_q, rd_vld_d;
    logic [DAT_W-1:0]  x_q, x_d;
    logic              init_s_q, init_s_d;
    logic [DAT_W-1:0]  bg_hold_q, bg_hold_d;
    logic [DAT_W-1:0]  bg_out;
    logic [DAT_W-1:0]  ram_rdata;

    logic              init_frame_q, init_frame_d;
    logic              clear_pend_q, clear_pend_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic              wb_err_q, wb_err_d;

    always_comb begin
        afifo_full     = (afifo_cnt_q == CNT_W'(AFIFO_DEPTH));
        afifo_empty    = (afifo_cnt_q == '0);
        push_ok        = bus.cell_vld && !afifo_full;
        pop_ok         = bus.recur_valid && !afifo_empty;

        afifo_wr_ptr_d = push_ok ? ptr_inc(afifo_wr_ptr_q) : afifo_wr_ptr_q;
        afifo_rd_ptr_d = pop_ok  ? ptr_inc(afifo_rd_ptr_q) : afifo_rd_ptr_q;
        afifo_cnt_d    = afifo_cnt_q;
        if (push_ok && !pop_ok) afifo_cnt_d = afifo_cnt_q + CNT_W'(1);
        if (pop_ok && !push_ok) afifo_cnt_d = afifo_cnt_q - CNT_W'(1);

        wb_err_d = wb_err_q
                 | (bus.recur_valid && afifo_empty)
                 | (bus.cell_vld && afifo_full);

        // Init flag is captured per cell so a frame boundary cannot change the
        // background choice of a cell already in the read pipeline.
        rd_vld_d = bus.cell_vld;
        x_d      = bus.cell_vld ? bus.cell_din : x_q;
        init_s_d = bus.cell_vld ? init_frame_q : init_s_q;

        bg_out    = rd_vld_q ? (init_s_q ? x_q : ram_rdata) : bg_hold_q;
        bg_hold_d = bg_out;

        init_frame_d = init_frame_q;
        clear_pend_d = clear_pend_q;
        frame_cnt_d  = frame_cnt_q;
        if (frame_start) begin
            init_frame_d = clear_pend_q | clear_map;
            clear_pend_d = 1'b0;
            frame_cnt_d  = frame_cnt_q + 16'd1;
        end
        if (clear_map) clear_pend_d = 1'b1;
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            afifo_wr_ptr_q <= '0;
            afifo_rd_ptr_q <= '0;
            afifo_cnt_q    <= '0;
            rd_vld_q       <= 1'b0;
            x_q            <= '0;
            init_s_q       <= 1'b0;
            bg_hold_q      <= '0;
            init_frame_q   <= 1'b1;
            clear_pend_q   <= 1'b1;
            frame_cnt_q    <= '0;
            wb_err_q       <= 1'b0;
        end else begin
            afifo_wr_ptr_q <= afifo_wr_ptr_d;
            afifo_rd_ptr_q <= afifo_rd_ptr_d;
            afifo_cnt_q    <= afifo_cnt_d;
            rd_vld_q       <= rd_vld_d;
            x_q            <= x_d;
            init_s_q       <= init_s_d;
            bg_hold_q      <= bg_hold_d;
            init_frame_q   <= init_frame_d;
            clear_pend_q   <= clear_pend_d;
            frame_cnt_q    <= frame_cnt_d;
            wb_err_q       <= wb_err_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (push_ok) afifo_q[afifo_wr_ptr_q] <= bus.cell_addr;
    end

    clutmap_ram #(
        .ADDR_W (ADDR_W),
        .DAT_W  (DAT_W)
    ) u_ram (
        .clk    (sys_clk),
        .we     (pop_ok),
        .waddr  (afifo_q[afifo_rd_ptr_q]),
        .wdata  (bus.recur_dat),
        .re     (bus.cell_vld),
        .raddr  (bus.cell_addr),
        .rdata  (ram_rdata)
    );

    assign bus.radmap_rd_vld  = rd_vld_q;
    assign bus.radmap_rd_din0 = x_q;
    assign bus.radmap_rd_din2 = bg_out;
    assign bus.cm_vld         = rd_vld_q;
    assign bus.cm_x           = x_q;
    assign bus.cm_bg          = bg_out;
    assign init_frame         = init_frame_q;
    assign frame_cnt          = frame_cnt_q;
    assign wb_err             = wb_err_q;

endmodule

// File: tb/tb_clutmap_rw_ctrl.sv
// Directed bench for clutmap_rw_ctrl with a 6-cycle first-order recursion model
// (y = 0.1*x + 0.9*y(n-1)) closing the write-back loop.
module tb_clutmap_rw_ctrl;
    import clutmap_pkg::*;

    logic        sys_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        clear_map = 1'b0;
    logic        init_frame;
    logic [15:0] frame_cnt;
    logic        wb_err;
    logic        inj_vld = 1'b0;
    logic [15:0] inj_dat = 16'd0;
    int          checks = 0;
    int          failures = 0;

    always #5 sys_clk = ~sys_clk;

    clutmap_rw_ctrl_if #(.ADDR_W(12), .DAT_W(16)) bus ();

    clutmap_rw_ctrl dut (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .clear_map   (clear_map),
        .bus         (bus.slave),
        .init_frame  (init_frame),
        .frame_cnt   (frame_cnt),
        .wb_err      (wb_err)
    );

    // Recursion stage stand-in, k = 100/1000.
    function automatic logic [15:0] recur_f(input logic [15:0] x, input logic [15:0] y);
        int t;
        t = (100 * int'(x) + 900 * int'(y)) / 1000;
        return t[15:0];
    endfunction

    logic [5:0]  rv_q;
    logic [15:0] rd_q [6];

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) rv_q <= '0;
        else        rv_q <= {rv_q[4:0], bus.radmap_rd_vld};
    end

    always_ff @(posedge sys_clk) begin
        rd_q[0] <= recur_f(bus.radmap_rd_din0, bus.radmap_rd_din2);
        for (int k = 1; k < 6; k++) rd_q[k] <= rd_q[k-1];
    end

    assign bus.recur_valid = rv_q[5] | inj_vld;
    assign bus.recur_dat   = inj_vld ? inj_dat : rd_q[5];

    task automatic pulse_frame();
        @(posedge sys_clk); #1 frame_start = 1'b1;
        @(posedge sys_clk); #1 frame_start = 1'b0;
    endtask

    task automatic send_one(input logic [11:0] a, input logic [15:0] x,
                            input logic [15:0] exp_bg, input logic exp_init, input string nm);
        @(posedge sys_clk); #1;
        bus.cell_vld = 1'b1; bus.cell_addr = a; bus.cell_din = x;
        @(posedge sys_clk); #1 bus.cell_vld = 1'b0;
        @(negedge sys_clk);
        if (bus.radmap_rd_vld !== 1'b1 || bus.cm_vld !== 1'b1) begin
            failures++; $display("FAIL %s_vld rd_vld=%b cm_vld=%b want 1", nm, bus.radmap_rd_vld, bus.cm_vld);
        end
        checks++;
        if (bus.radmap_rd_din0 !== x || bus.cm_x !== x) begin
            failures++; $display("FAIL %s_x din0=%0d cm_x=%0d want %0d", nm, bus.radmap_rd_din0, bus.cm_x, x);
        end
        checks++;
        if (bus.radmap_rd_din2 !== exp_bg || bus.cm_bg !== exp_bg) begin
            failures++; $display("FAIL %s_bg din2=%0d cm_bg=%0d want %0d", nm, bus.radmap_rd_din2, bus.cm_bg, exp_bg);
        end
        checks++;
        if (init_frame !== exp_init) begin
            failures++; $display("FAIL %s_init got %b want %b", nm, init_frame, exp_init);
        end
        checks++;
        repeat (9) @(posedge sys_clk);
        @(negedge sys_clk);
        if (bus.cm_vld !== 1'b0 || bus.cm_bg !== exp_bg || bus.cm_x !== x) begin
            failures++; $display("FAIL %s_hold vld=%b bg=%0d x=%0d want 0/%0d/%0d", nm, bus.cm_vld, bus.cm_bg, bus.cm_x, exp_bg, x);
        end
        checks++;
    endtask

    // 64 back-to-back cells to addr 0..63 with x = 200+8*i+xoff; expected
    // background is x itself in init frames, else 200+8*i+bgoff.
    task automatic run_pass(input int xoff, input int bgoff, input logic init, input string nm);
        int x, bg, maxcnt, bad;
        maxcnt = 0; bad = 0;
        for (int j = 0; j <= 64; j++) begin
            @(posedge sys_clk); #1;
            if (j < 64) begin
                bus.cell_vld = 1'b1; bus.cell_addr = 12'(j); bus.cell_din = 16'(200 + 8*j + xoff);
            end else begin
                bus.cell_vld = 1'b0;
            end
            @(negedge sys_clk);
            if (int'(dut.afifo_cnt_q) > maxcnt) maxcnt = int'(dut.afifo_cnt_q);
            if (j >= 1) begin
                x  = 200 + 8*(j-1) + xoff;
                bg = init ? x : 200 + 8*(j-1) + bgoff;
                if (bus.radmap_rd_vld !== 1'b1 || bus.cm_x !== 16'(x) || bus.cm_bg !== 16'(bg)
                    || bus.radmap_rd_din2 !== 16'(bg) || init_frame !== init) begin
                    if (bad < 4) $display("FAIL %s_cell%0d vld=%b x=%0d bg=%0d init=%b want 1/%0d/%0d/%b",
                                          nm, j-1, bus.radmap_rd_vld, bus.cm_x, bus.cm_bg, init_frame, x, bg, init);
                    bad++; failures++;
                end
                checks++;
            end
        end
        repeat (10) @(posedge sys_clk);
        @(negedge sys_clk);
        if (maxcnt !== 7) begin
            failures++; $display("FAIL %s_fifo_peak got %0d want 7", nm, maxcnt);
        end
        checks++;
        if (int'(dut.afifo_cnt_q) !== 0) begin
            failures++; $display("FAIL %s_fifo_drain got %0d want 0", nm, dut.afifo_cnt_q);
        end
        checks++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        if (bus.radmap_rd_vld !== 1'b0 || bus.cm_vld !== 1'b0 || bus.cm_x !== 16'd0 || bus.cm_bg !== 16'd0
            || bus.radmap_rd_din0 !== 16'd0 || bus.radmap_rd_din2 !== 16'd0) begin
            failures++; $display("FAIL reset_bus vld=%b x=%0d bg=%0d want 0", bus.cm_vld, bus.cm_x, bus.cm_bg);
        end
        checks++;
        if (init_frame !== 1'b1 || frame_cnt !== 16'd0 || wb_err !== 1'b0) begin
            failures++; $display("FAIL reset_ctrl init=%b cnt=%0d err=%b want 1/0/0", init_frame, frame_cnt, wb_err);
        end
        checks++;
        @(posedge sys_clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_recursion();
        pulse_frame();
        send_one(12'd3, 16'd500, 16'd500, 1'b1, "init_cell");
        pulse_frame();
        send_one(12'd3, 16'd1500, 16'd500, 1'b0, "frame2");
        pulse_frame();
        send_one(12'd3, 16'd100, 16'd600, 1'b0, "frame3");
        if (frame_cnt !== 16'd3 || wb_err !== 1'b0) begin
            failures++; $display("FAIL frame_cnt3 cnt=%0d err=%b want 3/0", frame_cnt, wb_err);
        end
        checks++;
    endtask

    task automatic test_clear_map();
        @(posedge sys_clk); #1 clear_map = 1'b1;
        @(posedge sys_clk); #1 clear_map = 1'b0;
        pulse_frame();
        run_pass(0, 0, 1'b1, "clear_init");
    endtask

    task automatic test_back_to_back();
        pulse_frame();
        run_pass(1000, 0, 1'b0, "b2b_a");
        pulse_frame();
        run_pass(100, 100, 1'b0, "b2b_b");
        if (wb_err !== 1'b0 || frame_cnt !== 16'd6) begin
            failures++; $display("FAIL b2b_status err=%b cnt=%0d want 0/6", wb_err, frame_cnt);
        end
        checks++;
    endtask

    task automatic test_spurious();
        @(posedge sys_clk); #1 inj_vld = 1'b1; inj_dat = 16'hBEEF;
        @(posedge sys_clk); #1 inj_vld = 1'b0;
        @(negedge sys_clk);
        if (wb_err !== 1'b1 || int'(dut.afifo_cnt_q) !== 0) begin
            failures++; $display("FAIL spurious_err err=%b cnt=%0d want 1/0", wb_err, dut.afifo_cnt_q);
        end
        checks++;
        pulse_frame();
        run_pass(100, 100, 1'b0, "after_spur");
        if (wb_err !== 1'b1) begin
            failures++; $display("FAIL spurious_sticky got %b want 1", wb_err);
        end
        checks++;
    endtask

    task automatic test_reset_midflight();
        int rv_seen;
        pulse_frame();
        for (int j = 0; j < 4; j++) begin
            @(posedge sys_clk); #1;
            bus.cell_vld = 1'b1; bus.cell_addr = 12'(10 + j); bus.cell_din = 16'(9000 + j);
        end
        @(posedge sys_clk); #1 bus.cell_vld = 1'b0; rst_n = 1'b0;
        @(negedge sys_clk);
        if (bus.cm_vld !== 1'b0 || bus.radmap_rd_vld !== 1'b0 || bus.cm_x !== 16'd0 || bus.cm_bg !== 16'd0) begin
            failures++; $display("FAIL midrst_bus vld=%b x=%0d bg=%0d want 0", bus.cm_vld, bus.cm_x, bus.cm_bg);
        end
        checks++;
        if (init_frame !== 1'b1 || frame_cnt !== 16'd0 || wb_err !== 1'b0 || int'(dut.afifo_cnt_q) !== 0) begin
            failures++; $display("FAIL midrst_ctrl init=%b cnt=%0d err=%b fifo=%0d want 1/0/0/0",
                                 init_frame, frame_cnt, wb_err, dut.afifo_cnt_q);
        end
        checks++;
        repeat (2) @(posedge sys_clk);
        #1 rst_n = 1'b1;
        rv_seen = 0;
        repeat (12) begin
            @(negedge sys_clk);
            if (bus.recur_valid === 1'b1) rv_seen++;
        end
        if (rv_seen !== 0 || wb_err !== 1'b0) begin
            failures++; $display("FAIL midrst_nowb recur=%0d err=%b want 0/0", rv_seen, wb_err);
        end
        checks++;
        pulse_frame();
        pulse_frame();
        send_one(12'd10, 16'd1000, 16'd380, 1'b0, "midrst_map");
        if (frame_cnt !== 16'd2) begin
            failures++; $display("FAIL midrst_cnt got %0d want 2", frame_cnt);
        end
        checks++;
    endtask

    initial begin
        bus.cell_vld  = 1'b0;
        bus.cell_addr = '0;
        bus.cell_din  = '0;
        test_reset();
        test_recursion();
        test_clear_map();
        test_back_to_back();
        test_spurious();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
